// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared source-tag encoding and arbitration-mode constants
//   SEL_A / SEL_B  : source tag carried on out_sel, same encoding as dmux sel
//   PRIO_RR / PRIO_FIXED : arbitration mode values for PRIO_MODE
package stream_mux_pkg;
    typedef logic sel_t;
    localparam sel_t SEL_A = 1'b0;
    localparam sel_t SEL_B = 1'b1;
    localparam int PRIO_RR = 0;
    localparam int PRIO_FIXED = 1;
endpackage

// File: rtl/stream_mux2_arb.sv
// stream_mux2_arb: two-source grant logic with round-robin or fixed priority pointer
//   clk, rst_n       : clock, synchronous active-low reset
//   a_valid, b_valid : source requests
//   load             : output stage can take a word this cycle
//   grant_a, grant_b : one-hot (or zero) grant, independent of load
module stream_mux2_arb
    import stream_mux_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_valid,
    input  logic b_valid,
    input  logic load,
    output logic grant_a,
    output logic grant_b
);
    sel_t prio;

    always_comb begin
        grant_a = a_valid && (!b_valid || prio == SEL_A);
        grant_b = b_valid && !grant_a;
    end

    // In fixed mode prio never leaves SEL_A, so A always wins a tie.
    always_ff @(posedge clk) begin
        if (!rst_n)
            prio <= SEL_A;
        else if (PRIO_MODE == PRIO_RR && load && (grant_a || grant_b))
            prio <= grant_a ? SEL_B : SEL_A;
    end
endmodule

// File: rtl/stream_mux2.sv
// stream_mux2: 2-to-1 valid/ready stream merger with registered, source-tagged output
//   clk, rst_n                   : clock, synchronous active-low reset
//   a_valid/a_data/a_ready       : source A (tag SEL_A)
//   b_valid/b_data/b_ready       : source B (tag SEL_B)
//   out_valid/out_data/out_sel/out_ready : merged output
//   STREAM_MUX2_SKID_EN : when defined, the output stage is a 2-entry FIFO and the
//                         readies no longer depend combinationally on out_ready
module stream_mux2
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output sel_t             out_sel,
    input  logic             out_ready
);
    logic grant_a, grant_b, load, accept;
    sel_t in_sel;
    logic [WIDTH-1:0] in_data;

    stream_mux2_arb #(.PRIO_MODE(PRIO_MODE)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .load    (load),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    // Readies are held low during reset so nothing is consumed from a source.
    always_comb begin
        a_ready = rst_n && load && grant_a;
        b_ready = rst_n && load && grant_b;
        accept  = a_ready || b_ready;
        in_sel  = b_ready ? SEL_B : SEL_A;
        in_data = b_ready ? b_data : a_data;
    end

`ifdef STREAM_MUX2_SKID_EN
    logic [1:0] count;
    logic wr, rd, pop;
    logic [WIDTH:0] mem [2];

    // load comes only from registered count, cutting the out_ready -> ready path.
    always_comb begin
        load = count < 2'd2;
        out_valid = count != 2'd0;
        {out_sel, out_data} = mem[rd];
        pop = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr     <= 1'b0;
            rd     <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (accept) begin
                mem[wr] <= {in_sel, in_data};
                wr      <= !wr;
            end
            if (pop)
                rd <= !rd;
            count <= count + {1'b0, accept} - {1'b0, pop};
        end
    end
`else
    assign load = !out_valid || out_ready;

    // A new word may enter in the same cycle the held word leaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= SEL_A;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_sel   <= in_sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_stream_mux2.sv
// tb_stream_mux2: self-checking bench for stream_mux2, round-robin and fixed-priority instances
module tb_stream_mux2;
`ifdef STREAM_MUX2_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst_n, a_valid, b_valid, out_ready;
    logic [7:0] a_data, b_data;
    logic [1:0] ar, br, ov, os;
    logic [7:0] od [2];

    always #5 clk = ~clk;

    stream_mux2 #(.WIDTH(8), .PRIO_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(ar[0]),
        .b_valid(b_valid), .b_data(b_data), .b_ready(br[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_sel(os[0]), .out_ready(out_ready)
    );

    stream_mux2 #(.WIDTH(8), .PRIO_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(ar[1]),
        .b_valid(b_valid), .b_data(b_data), .b_ready(br[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_sel(os[1]), .out_ready(out_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per instance, an ordered list of pending output words
    // (capacity CAP), a preference bit, and the source rules.
    int cnt [2];
    logic [8:0] ent [2][2];
    bit prio [2];
    bit ea [2];
    bit eb [2];

    task automatic step();
        #1;
        for (int m = 0; m < 2; m++) begin
            bit ld, ga;
            ld = (CAP == 1) ? (cnt[m] == 0 || out_ready) : (cnt[m] < 2);
            ga = a_valid && (!b_valid || !prio[m]);
            ea[m] = rst_n && ld && ga;
            eb[m] = rst_n && ld && b_valid && !ga;
            chk($sformatf("a_ready[%0d]", m), int'(ar[m]), int'(ea[m]));
            chk($sformatf("b_ready[%0d]", m), int'(br[m]), int'(eb[m]));
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                cnt[m] = 0;
                prio[m] = 0;
            end else begin
                if (cnt[m] > 0 && out_ready) begin
                    ent[m][0] = ent[m][1];
                    cnt[m]--;
                end
                if (ea[m] || eb[m]) begin
                    ent[m][cnt[m]] = eb[m] ? {1'b1, b_data} : {1'b0, a_data};
                    cnt[m]++;
                    if (m == 0) prio[m] = !eb[m];
                end
            end
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("out_valid[%0d]", m), int'(ov[m]), int'(cnt[m] > 0));
            if (cnt[m] > 0) begin
                chk($sformatf("out_data[%0d]", m), int'(od[m]), int'(ent[m][0][7:0]));
                chk($sformatf("out_sel[%0d]", m), int'(os[m]), int'(ent[m][0][8]));
            end
        end
    endtask

    task automatic drive(input bit rn, input bit av, input logic [7:0] ad,
                         input bit bv, input logic [7:0] bd, input bit ordy);
        rst_n = rn; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    endtask

    typedef struct {
        bit rn; bit av; logic [7:0] ad; bit bv; logic [7:0] bd; bit ordy;
        bit ar; bit br; bit ov; logic [7:0] od; bit os;
    } vec_t;

    vec_t tbl [10];

    initial begin
        for (int m = 0; m < 2; m++) begin
            cnt[m] = 0; prio[m] = 0; ea[m] = 0; eb[m] = 0;
        end
        drive(0, 1, 8'h00, 1, 8'h00, 1);

        // Reset with both sources requesting
        repeat (3) step();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("reset out_data[%0d]", m), int'(od[m]), 0);
            chk($sformatf("reset out_sel[%0d]", m), int'(os[m]), 0);
        end

        // Directed RR vectors for dut0 (out_ready held high, identical in both builds)
        tbl[0] = '{0, 1, 8'h00, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0};
        tbl[1] = '{1, 1, 8'h11, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0};
        tbl[2] = '{1, 1, 8'h12, 0, 8'h00, 1, 1, 0, 1, 8'h12, 0};
        tbl[3] = '{1, 1, 8'hA0, 1, 8'hB0, 1, 0, 1, 1, 8'hB0, 1};
        tbl[4] = '{1, 1, 8'hA0, 1, 8'hB1, 1, 1, 0, 1, 8'hA0, 0};
        tbl[5] = '{1, 1, 8'hA1, 1, 8'hB1, 1, 0, 1, 1, 8'hB1, 1};
        tbl[6] = '{1, 1, 8'hA1, 1, 8'hB2, 1, 1, 0, 1, 8'hA1, 0};
        tbl[7] = '{1, 1, 8'hA2, 1, 8'hB2, 1, 0, 1, 1, 8'hB2, 1};
        tbl[8] = '{1, 1, 8'hA2, 1, 8'hB3, 1, 1, 0, 1, 8'hA2, 0};
        tbl[9] = '{1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rn, tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].ordy);
            #1;
            chk($sformatf("tbl%0d a_ready", i), int'(ar[0]), int'(tbl[i].ar));
            chk($sformatf("tbl%0d b_ready", i), int'(br[0]), int'(tbl[i].br));
            step();
            chk($sformatf("tbl%0d out_valid", i), int'(ov[0]), int'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d out_data", i), int'(od[0]), int'(tbl[i].od));
                chk($sformatf("tbl%0d out_sel", i), int'(os[0]), int'(tbl[i].os));
            end
        end

        // Backpressure: hold 0x22 from B, stall for 5 cycles, then release
        drive(1, 0, 8'h00, 1, 8'h22, 1);
        step();
        drive(1, 1, 8'h33, 1, 8'h44, 0);
        for (int i = 0; i < 5; i++) begin
`ifndef STREAM_MUX2_SKID_EN
            #1;
            chk("bp a_ready", int'(ar[0]), 0);
            chk("bp b_ready", int'(br[0]), 0);
`endif
            step();
            chk("bp out_data", int'(od[0]), 8'h22);
            chk("bp out_sel", int'(os[0]), 1);
        end
        drive(1, 1, 8'h33, 1, 8'h44, 1);
        step();
        chk("release out_sel", int'(os[0]), 0);
        chk("release out_data", int'(od[0]), 8'h33);

        // Fixed priority: A always wins, B only when A idle
        drive(0, 0, 8'h00, 0, 8'h00, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 8'h50 + 8'(i), 1, 8'h60 + 8'(i), 1);
            step();
            chk("fixed out_sel", int'(os[1]), 0);
        end
        drive(1, 0, 8'h00, 1, 8'h66, 1);
        #1;
        chk("fixed b_ready", int'(br[1]), 1);
        step();
        chk("fixed B served", int'(os[1]), 1);

        // Mid-stream reset pulse
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 8'hA0 + 8'(i), 1, 8'hB0 + 8'(i), 1);
            step();
        end
        drive(0, 1, 8'hA3, 1, 8'hB3, 1);
        step();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("midrst out_valid[%0d]", m), int'(ov[m]), 0);
            chk($sformatf("midrst out_data[%0d]", m), int'(od[m]), 0);
        end
        drive(1, 1, 8'hA4, 1, 8'hB4, 1);
        step();
        chk("post-reset out_sel", int'(os[0]), 0);
        chk("post-reset out_data", int'(od[0]), 8'hA4);

        // Randomized traffic; a pending source holds its word until dut0 takes it
        for (int i = 0; i < 600; i++) begin
            bit keep_a, keep_b;
            keep_a = a_valid && !ea[0] && rst_n;
            keep_b = b_valid && !eb[0] && rst_n;
            rst_n = ($urandom_range(0, 59) != 0);
            if (!keep_a) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_data = 8'($urandom);
            end
            if (!keep_b) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_data = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
